// File: rtl/sram_frame_scheduler_pkg.sv
// rtl/sram_frame_scheduler_pkg.sv - shared types, defaults and address packing for the SRAM frame scheduler
package sram_frame_pkg;

    localparam int          H_RES_DEF    = 640;
    localparam int          V_RES_DEF    = 480;
    localparam logic [15:0] BG_COLOR_DEF = 16'h001F;

    typedef enum logic [1:0] {
        CLEAR,
        DRAW,
        WAIT_SWAP
    } state_e;

    typedef struct packed {
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic        dq_oe;
        logic [19:0] addr;
        logic [15:0] dq;
    } sram_pins_t;

    localparam sram_pins_t PINS_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0,
                                         addr: 20'd0, dq: 16'd0};

    function automatic logic [19:0] pack_addr(input logic b, input logic [8:0] y, input logic [9:0] x);
        return {b, y, x};
    endfunction

endpackage

// File: rtl/sram_frame_scheduler_if.sv
// rtl/sram_frame_scheduler_if.sv - display read and sprite draw channels of the SRAM frame scheduler
interface sram_frame_scheduler_if;

    logic        vga_rd_req;
    logic [9:0]  vga_rd_x;
    logic [9:0]  vga_rd_y;
    logic        vga_rd_valid;
    logic [15:0] vga_rd_data;

    logic        draw_valid;
    logic        draw_ready;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [15:0] draw_data;

    modport master (
        output vga_rd_req, vga_rd_x, vga_rd_y,
        input  vga_rd_valid, vga_rd_data,
        output draw_valid, draw_x, draw_y, draw_data,
        input  draw_ready
    );

    modport slave (
        input  vga_rd_req, vga_rd_x, vga_rd_y,
        output vga_rd_valid, vga_rd_data,
        input  draw_valid, draw_x, draw_y, draw_data,
        output draw_ready
    );

endinterface

// File: rtl/sram_frame_scheduler_clear_counter.sv
// rtl/sram_frame_scheduler_clear_counter.sv - raster x/y walker feeding the background clear engine
module sram_clear_counter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic       sram_clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       restart,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       done
);

    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (restart) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 9'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge sram_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign done = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/sram_frame_scheduler.sv
// rtl/sram_frame_scheduler.sv - shares one SRAM between display reads, clear and draw writes; double-buffer swap at vsync
module sram_frame_scheduler
    import sram_frame_pkg::*;
#(
    parameter int          H_RES    = H_RES_DEF,
    parameter int          V_RES    = V_RES_DEF,
    parameter logic [15:0] BG_COLOR = BG_COLOR_DEF
) (
    input  logic                    sram_clk,
    input  logic                    reset_n,
    input  logic                    frame_sync,
    input  logic                    frame_done,
    sram_frame_scheduler_if.slave   bus,
    output logic                    disp_buf,
    output logic                    clearing,
    output logic                    SRAM_CE_N,
    output logic                    SRAM_UB_N,
    output logic                    SRAM_LB_N,
    output logic                    SRAM_OE_N,
    output logic                    SRAM_WE_N,
    output logic [19:0]             SRAM_ADDR,
    inout  wire  [15:0]             SRAM_DQ
);

    localparam logic [9:0] X_LIM = 10'(H_RES);
    localparam logic [9:0] Y_LIM = 10'(V_RES);

    state_e     state_q, state_d;
    logic       disp_q, disp_d;
    logic       done_pend_q, done_pend_d;
    logic       sync_prev_q, sync_prev_d;
    sram_pins_t pins_q, pins_d;

    logic        rd_v1_q, rd_v1_d, rd_oor1_q, rd_oor1_d;
    logic        rd_v2_q, rd_v2_d, rd_oor2_q, rd_oor2_d;
    logic [15:0] dq_cap_q, dq_cap_d;
    logic        rd_valid_q, rd_valid_d;
    logic [15:0] rd_data_q, rd_data_d;

    logic       clr_en, clr_restart, clr_done;
    logic [9:0] clr_x;
    logic [8:0] clr_y;
    logic       rd_in_range, draw_in_range, sync_rise;

    sram_clear_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_clr (
        .sram_clk (sram_clk),
        .reset_n  (reset_n),
        .en       (clr_en),
        .restart  (clr_restart),
        .x        (clr_x),
        .y        (clr_y),
        .done     (clr_done)
    );

    assign rd_in_range   = (bus.vga_rd_x < X_LIM) && (bus.vga_rd_y < Y_LIM);
    assign draw_in_range = (bus.draw_x < X_LIM) && (bus.draw_y < Y_LIM);
    assign sync_rise     = frame_sync && !sync_prev_q;
    assign sync_prev_d   = frame_sync;

    always_comb begin
        state_d        = state_q;
        disp_d         = disp_q;
        done_pend_d    = done_pend_q;
        pins_d         = PINS_IDLE;
        pins_d.addr    = pins_q.addr;
        pins_d.dq      = pins_q.dq;
        clr_en         = 1'b0;
        clr_restart    = 1'b0;
        bus.draw_ready = 1'b0;

        // A pending display read owns the bus this cycle, even when it needs no SRAM access.
        if (bus.vga_rd_req && rd_in_range) begin
            pins_d.ce_n = 1'b0;
            pins_d.oe_n = 1'b0;
            pins_d.addr = pack_addr(disp_q, bus.vga_rd_y[8:0], bus.vga_rd_x);
        end

        case (state_q)
            CLEAR: begin
                if (frame_done) done_pend_d = 1'b1;
                if (!bus.vga_rd_req) begin
                    pins_d.ce_n  = 1'b0;
                    pins_d.we_n  = 1'b0;
                    pins_d.dq_oe = 1'b1;
                    pins_d.dq    = BG_COLOR;
                    pins_d.addr  = pack_addr(~disp_q, clr_y, clr_x);
                    clr_en       = 1'b1;
                    if (clr_done) begin
                        state_d     = (done_pend_q || frame_done) ? WAIT_SWAP : DRAW;
                        done_pend_d = 1'b0;
                    end
                end
            end
            DRAW: begin
                bus.draw_ready = !bus.vga_rd_req;
                if (bus.draw_valid && !bus.vga_rd_req && draw_in_range) begin
                    pins_d.ce_n  = 1'b0;
                    pins_d.we_n  = 1'b0;
                    pins_d.dq_oe = 1'b1;
                    pins_d.dq    = bus.draw_data;
                    pins_d.addr  = pack_addr(~disp_q, bus.draw_y[8:0], bus.draw_x);
                end
                if (frame_done) state_d = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (sync_rise) begin
                    disp_d      = ~disp_q;
                    clr_restart = 1'b1;
                    state_d     = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        rd_v1_d    = bus.vga_rd_req;
        rd_oor1_d  = !rd_in_range;
        rd_v2_d    = rd_v1_q;
        rd_oor2_d  = rd_oor1_q;
        dq_cap_d   = rd_v1_q ? SRAM_DQ : dq_cap_q;
        rd_valid_d = rd_v2_q;
        rd_data_d  = rd_data_q;
        if (rd_v2_q) rd_data_d = rd_oor2_q ? BG_COLOR : dq_cap_q;
    end

    always_ff @(posedge sram_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            disp_q      <= 1'b0;
            done_pend_q <= 1'b0;
            sync_prev_q <= 1'b0;
            pins_q      <= PINS_IDLE;
            rd_v1_q     <= 1'b0;
            rd_oor1_q   <= 1'b0;
            rd_v2_q     <= 1'b0;
            rd_oor2_q   <= 1'b0;
            dq_cap_q    <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            disp_q      <= disp_d;
            done_pend_q <= done_pend_d;
            sync_prev_q <= sync_prev_d;
            pins_q      <= pins_d;
            rd_v1_q     <= rd_v1_d;
            rd_oor1_q   <= rd_oor1_d;
            rd_v2_q     <= rd_v2_d;
            rd_oor2_q   <= rd_oor2_d;
            dq_cap_q    <= dq_cap_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign disp_buf         = disp_q;
    assign clearing         = (state_q == CLEAR);
    assign bus.vga_rd_valid = rd_valid_q;
    assign bus.vga_rd_data  = rd_data_q;
    assign SRAM_CE_N        = pins_q.ce_n;
    assign SRAM_UB_N        = pins_q.ce_n;
    assign SRAM_LB_N        = pins_q.ce_n;
    assign SRAM_OE_N        = pins_q.oe_n;
    assign SRAM_WE_N        = pins_q.we_n;
    assign SRAM_ADDR        = pins_q.addr;
    assign SRAM_DQ          = pins_q.dq_oe ? pins_q.dq : 16'bz;

endmodule

// File: tb/tb_sram_frame_scheduler.sv
// tb/tb_sram_frame_scheduler.sv - scoreboard bench for the SRAM frame scheduler
module tb_sram_frame_scheduler;

    localparam int          HR = 32;
    localparam int          VR = 24;
    localparam logic [15:0] BG = 16'h001F;

    logic        sram_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_sync = 1'b0;
    logic        frame_done = 1'b0;
    logic        disp_buf, clearing;
    logic        ce_n, ub_n, lb_n, oe_n, we_n;
    logic [19:0] sram_addr;
    wire  [15:0] sram_dq;

    int   errors = 0;
    int   checks = 0;
    logic exp_disp = 1'b0;

    typedef struct { logic [19:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [15:0] data; int due; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];

    sram_frame_scheduler_if bus();

    sram_frame_scheduler #(.H_RES(HR), .V_RES(VR), .BG_COLOR(BG)) dut (
        .sram_clk   (sram_clk),
        .reset_n    (reset_n),
        .frame_sync (frame_sync),
        .frame_done (frame_done),
        .bus        (bus.slave),
        .disp_buf   (disp_buf),
        .clearing   (clearing),
        .SRAM_CE_N  (ce_n),
        .SRAM_UB_N  (ub_n),
        .SRAM_LB_N  (lb_n),
        .SRAM_OE_N  (oe_n),
        .SRAM_WE_N  (we_n),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ    (sram_dq)
    );

    always #5 sram_clk = ~sram_clk;

    // SRAM model: a read returns the low 16 address bits
    assign sram_dq = (!oe_n && !ce_n && we_n) ? sram_addr[15:0] : 16'bz;

    function automatic logic [19:0] tb_addr(input logic b, input int y, input int x);
        return {b, 9'(y), 10'(x)};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge sram_clk);
        checks++; if (disp_buf !== 1'b0) begin errors++; $display("FAIL reset_disp_buf got=%0b want=0", disp_buf); end
        checks++; if (clearing !== 1'b1) begin errors++; $display("FAIL reset_clearing got=%0b want=1", clearing); end
        checks++; if (bus.draw_ready !== 1'b0) begin errors++; $display("FAIL reset_draw_ready got=%0b want=0", bus.draw_ready); end
        checks++; if (bus.vga_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%0b want=0", bus.vga_rd_valid); end
        checks++; if (bus.vga_rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got=%h want=0000", bus.vga_rd_data); end
        checks++; if ({ce_n, ub_n, lb_n, oe_n, we_n} !== 5'b11111) begin errors++; $display("FAIL reset_ctrl got=%b want=11111", {ce_n, ub_n, lb_n, oe_n, we_n}); end
        checks++; if (sram_addr !== 20'h0) begin errors++; $display("FAIL reset_addr got=%h want=00000", sram_addr); end
        reset_n = 1'b1;
    endtask

    task automatic test_clear(input bit inject);
        int  n = 0;
        int  reads = 0;
        wr_t w;
        logic b = ~exp_disp;
        for (int y = 0; y < VR; y++)
            for (int x = 0; x < HR; x++)
                wr_q.push_back('{tb_addr(b, y, x), BG});
        for (int c = 0; c < HR * VR + 50; c++) begin
            @(negedge sram_clk);
            if (!oe_n) reads++;
            if (!we_n) begin
                n++;
                if (wr_q.size() > 0) begin
                    w = wr_q.pop_front();
                    checks++;
                    if ({sram_addr, sram_dq, ub_n, lb_n} !== {w.addr, w.data, 2'b00}) begin
                        errors++;
                        $display("FAIL clear_write got addr=%h dq=%h want addr=%h dq=%h", sram_addr, sram_dq, w.addr, w.data);
                    end
                end
            end
            if (inject) begin
                if (c == 3) frame_sync = 1'b1;
                if (c == 7) frame_done = 1'b1;
                if (c == 8) frame_done = 1'b0;
            end
            if (!clearing) break;
        end
        checks++; if (n !== HR * VR) begin errors++; $display("FAIL clear_count got=%0d want=%0d", n, HR * VR); end
        checks++; if (reads !== 0) begin errors++; $display("FAIL clear_no_reads got=%0d want=0", reads); end
        checks++; if (clearing !== 1'b0) begin errors++; $display("FAIL clear_end got=%0b want=0", clearing); end
        checks++; if (disp_buf !== exp_disp) begin errors++; $display("FAIL clear_disp_buf got=%0b want=%0b", disp_buf, exp_disp); end
        wr_q.delete();
        #1;
        checks++;
        if (bus.draw_ready !== !inject) begin
            errors++;
            $display("FAIL clear_then_ready got=%0b want=%0b", bus.draw_ready, !inject);
        end
    endtask

    task automatic test_draw_single();
        wr_t w;
        @(negedge sram_clk);
        bus.draw_valid = 1'b1; bus.draw_x = 10'd10; bus.draw_y = 10'd20; bus.draw_data = 16'hF800;
        wr_q.push_back('{tb_addr(~exp_disp, 20, 10), 16'hF800});
        #1;
        checks++; if (bus.draw_ready !== 1'b1) begin errors++; $display("FAIL draw_ready got=%0b want=1", bus.draw_ready); end
        @(negedge sram_clk);
        bus.draw_valid = 1'b0;
        w = wr_q.pop_front();
        checks++;
        if ({we_n, oe_n, ce_n, sram_addr, sram_dq} !== {2'b01, 1'b0, w.addr, w.data}) begin
            errors++;
            $display("FAIL draw_write got we=%0b oe=%0b addr=%h dq=%h want we=0 oe=1 addr=%h dq=%h", we_n, oe_n, sram_addr, sram_dq, w.addr, w.data);
        end
        @(negedge sram_clk);
        checks++; if ({we_n, oe_n} !== 2'b11) begin errors++; $display("FAIL draw_release got we/oe=%b want=11", {we_n, oe_n}); end
    endtask

    task automatic test_back_to_back();
        rd_t  r;
        wr_t  w;
        logic [19:0] a;
        for (int c = 0; c < 10; c++) begin
            @(negedge sram_clk);
            if (bus.vga_rd_valid) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_valid at cycle %0d", c);
                end else begin
                    r = rd_q.pop_front();
                    if (c !== r.due || bus.vga_rd_data !== r.data) begin
                        errors++;
                        $display("FAIL b2b_read got cycle=%0d data=%h want cycle=%0d data=%h", c, bus.vga_rd_data, r.due, r.data);
                    end
                end
            end
            if (!we_n) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_write at cycle %0d addr=%h", c, sram_addr);
                end else begin
                    w = wr_q.pop_front();
                    if ({sram_addr, sram_dq} !== {w.addr, w.data}) begin
                        errors++;
                        $display("FAIL b2b_write got addr=%h dq=%h want addr=%h dq=%h", sram_addr, sram_dq, w.addr, w.data);
                    end
                end
            end
            if (c < 4) begin
                bus.vga_rd_req = 1'b1; bus.vga_rd_x = 10'(3 + c); bus.vga_rd_y = 10'(2 + c);
                a = tb_addr(exp_disp, 2 + c, 3 + c);
                rd_q.push_back('{a[15:0], c + 3});
            end else begin
                bus.vga_rd_req = 1'b0;
            end
            if (c == 0) begin
                bus.draw_valid = 1'b1; bus.draw_x = 10'd5; bus.draw_y = 10'd6; bus.draw_data = 16'h1234;
            end
            if (c == 4) wr_q.push_back('{tb_addr(~exp_disp, 6, 5), 16'h1234});
            if (c == 5) bus.draw_valid = 1'b0;
            #1;
            if (c < 5) begin
                checks++;
                if (bus.draw_ready !== (c >= 4)) begin
                    errors++; $display("FAIL b2b_draw_ready cycle=%0d got=%0b want=%0b", c, bus.draw_ready, c >= 4);
                end
            end
        end
        checks++; if (rd_q.size() !== 0) begin errors++; $display("FAIL b2b_missing_valid left=%0d want=0", rd_q.size()); end
        checks++; if (wr_q.size() !== 0) begin errors++; $display("FAIL b2b_missing_write left=%0d want=0", wr_q.size()); end
        rd_q.delete(); wr_q.delete();
    endtask

    task automatic test_oor_read();
        rd_t r;
        for (int c = 0; c < 6; c++) begin
            @(negedge sram_clk);
            checks++; if (oe_n !== 1'b1) begin errors++; $display("FAIL oor_read_oe cycle=%0d got=%0b want=1", c, oe_n); end
            if (bus.vga_rd_valid) begin
                checks++;
                if (rd_q.size() == 0) begin
                    errors++; $display("FAIL oor_extra_valid at cycle %0d", c);
                end else begin
                    r = rd_q.pop_front();
                    if (c !== r.due || bus.vga_rd_data !== r.data) begin
                        errors++;
                        $display("FAIL oor_read got cycle=%0d data=%h want cycle=%0d data=%h", c, bus.vga_rd_data, r.due, r.data);
                    end
                end
            end
            if (c == 0) begin
                bus.vga_rd_req = 1'b1; bus.vga_rd_x = 10'd700; bus.vga_rd_y = 10'd5;
                rd_q.push_back('{BG, 3});
            end else begin
                bus.vga_rd_req = 1'b0;
            end
        end
        checks++; if (rd_q.size() !== 0) begin errors++; $display("FAIL oor_missing_valid left=%0d want=0", rd_q.size()); end
        rd_q.delete();
    endtask

    task automatic test_oor_draw();
        @(negedge sram_clk);
        bus.draw_valid = 1'b1; bus.draw_x = 10'd40; bus.draw_y = 10'd3; bus.draw_data = 16'hABCD;
        #1;
        checks++; if (bus.draw_ready !== 1'b1) begin errors++; $display("FAIL oor_draw_ready got=%0b want=1", bus.draw_ready); end
        @(negedge sram_clk);
        bus.draw_valid = 1'b0;
        checks++; if (we_n !== 1'b1) begin errors++; $display("FAIL oor_draw_no_write got we=%0b want=1", we_n); end
    endtask

    task automatic test_swap();
        @(negedge sram_clk);
        frame_done = 1'b1;
        @(negedge sram_clk);
        frame_done = 1'b0;
        #1;
        checks++; if (bus.draw_ready !== 1'b0) begin errors++; $display("FAIL swap_wait_ready got=%0b want=0", bus.draw_ready); end
        checks++; if ({disp_buf, clearing} !== {exp_disp, 1'b0}) begin errors++; $display("FAIL swap_wait got disp/clr=%b want=%b", {disp_buf, clearing}, {exp_disp, 1'b0}); end
        repeat (2) @(negedge sram_clk);
        frame_sync = 1'b1;
        @(negedge sram_clk);
        frame_sync = 1'b0;
        exp_disp = ~exp_disp;
        checks++; if ({disp_buf, clearing} !== {exp_disp, 1'b1}) begin errors++; $display("FAIL swap got disp/clr=%b want=%b", {disp_buf, clearing}, {exp_disp, 1'b1}); end
    endtask

    task automatic test_late_swap();
        repeat (3) @(negedge sram_clk);
        #1;
        checks++; if ({disp_buf, clearing, bus.draw_ready} !== {exp_disp, 2'b00}) begin
            errors++; $display("FAIL late_hold got disp/clr/rdy=%b want=%b", {disp_buf, clearing, bus.draw_ready}, {exp_disp, 2'b00});
        end
        frame_sync = 1'b0;
        @(negedge sram_clk);
        frame_sync = 1'b1;
        @(negedge sram_clk);
        exp_disp = ~exp_disp;
        checks++; if ({disp_buf, clearing} !== {exp_disp, 1'b1}) begin errors++; $display("FAIL late_swap got disp/clr=%b want=%b", {disp_buf, clearing}, {exp_disp, 1'b1}); end
        frame_sync = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge sram_clk);
        checks++; if (we_n !== 1'b0) begin errors++; $display("FAIL areset_pre_write got we=%0b want=0", we_n); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if ({ce_n, we_n, oe_n} !== 3'b111) begin errors++; $display("FAIL areset_write_release got ce/we/oe=%b want=111", {ce_n, we_n, oe_n}); end
        @(negedge sram_clk);
        reset_n = 1'b1;
        exp_disp = 1'b0;
        bus.vga_rd_req = 1'b1; bus.vga_rd_x = 10'd1; bus.vga_rd_y = 10'd1;
        @(negedge sram_clk);
        bus.vga_rd_req = 1'b0;
        checks++; if (oe_n !== 1'b0) begin errors++; $display("FAIL areset_pre_read got oe=%0b want=0", oe_n); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if ({ce_n, oe_n} !== 2'b11) begin errors++; $display("FAIL areset_read_release got ce/oe=%b want=11", {ce_n, oe_n}); end
        @(negedge sram_clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge sram_clk);
            checks++; if (bus.vga_rd_valid !== 1'b0) begin errors++; $display("FAIL areset_valid_suppressed cycle=%0d got=1 want=0", c); end
        end
    endtask

    initial begin
        bus.vga_rd_req = 1'b0; bus.vga_rd_x = '0; bus.vga_rd_y = '0;
        bus.draw_valid = 1'b0; bus.draw_x = '0; bus.draw_y = '0; bus.draw_data = '0;
        test_reset();
        test_clear(1'b0);
        test_draw_single();
        test_back_to_back();
        test_oor_read();
        test_oor_draw();
        test_swap();
        test_clear(1'b1);
        test_late_swap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
